dm_subword_mem: RTL and testbench

//  Parametrised data memory for the CPU datapath. Supports byte, halfword and word stores and loads,

---
 rtl/dm_subword_mem.sv | 95 +++++++++
 tb/tb_dm_subword_mem.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/dm_subword_mem.sv
// dm_subword_mem: byte/half/word data memory with sign/zero-extending loads, req/ready handshake and fault flagging
module dm_subword_mem #(
  parameter int ADDR_W      = 32,
  parameter int DEPTH_WORDS = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_i,
  input  logic              wmem_i,
  input  logic [1:0]        size_i,
  input  logic              sign_ext_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       datain_i,
  output logic              ready_o,
  output logic              rvalid_o,
  output logic [31:0]       dataout_o,
  output logic              err_o
);
  localparam int IW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] LAT_M1 = 2'(RD_LAT - 1);
  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;
  state_t state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [31:0] mem [DEPTH_WORDS];
  logic [IW-1:0] idx_q, a_idx;
  logic [1:0] lane_q, size_q, a_lane, a_size;
  logic sign_q, fault_q, a_sign, a_fault;
  logic [31:0] dataout_q, word, ld_val, wdata;
  logic [15:0] sh;
  logic [3:0] be;
  logic err_q, idle, acc, oor, mis, fault;
  assign idle = state_q == IDLE;
  assign acc = req_i & idle;
  assign oor = (addr_i >> (IW + 2)) != '0;
  assign mis = (size_i == 2'b01 & addr_i[0]) | (size_i == 2'b10 & |addr_i[1:0]);
  assign fault = oor | mis | (size_i == 2'b11);
  // With RD_LAT=1 the response is computed on the accepting edge, so use live inputs while idle
  assign a_idx = idle ? addr_i[IW+1:2] : idx_q;
  assign a_lane = idle ? addr_i[1:0] : lane_q;
  assign a_size = idle ? size_i : size_q;
  assign a_sign = idle ? sign_ext_i : sign_q;
  assign a_fault = idle ? fault : fault_q;
  assign word = mem[a_idx];
  assign sh = 16'(word >> {a_lane, 3'b000});
  assign ld_val = a_fault ? 32'd0 :
                  a_size == 2'b00 ? {{24{a_sign & sh[7]}}, sh[7:0]} :
                  a_size == 2'b01 ? {{16{a_sign & sh[15]}}, sh} : word;
  assign wdata = size_i == 2'b00 ? {4{datain_i[7:0]}} :
                 size_i == 2'b01 ? {2{datain_i[15:0]}} : datain_i;
  assign be = size_i == 2'b00 ? 4'b0001 << addr_i[1:0] :
              size_i == 2'b01 ? (addr_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign ready_o = idle;
  assign rvalid_o = (state_q == RESP) & ~rst;
  assign err_o = err_q & ~rst;
  assign dataout_o = dataout_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    if (acc && !wmem_i) begin
      state_d = RD_LAT == 1 ? RESP : RD;
      cnt_d = LAT_M1;
    end else if (state_q == RD) begin
      cnt_d = cnt_q - 2'd1;
      state_d = cnt_q == 2'd1 ? RESP : RD;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q <= '0;
      dataout_q <= '0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      err_q <= (acc & wmem_i & fault) | (state_d == RESP & a_fault);
      if (state_d == RESP) dataout_q <= ld_val;
      if (acc) begin
        idx_q <= addr_i[IW+1:2];
        lane_q <= addr_i[1:0];
        size_q <= size_i;
        sign_q <= sign_ext_i;
        fault_q <= fault;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && acc && wmem_i && !fault)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[addr_i[IW+1:2]][8*b +: 8] <= wdata[8*b +: 8];
  end
endmodule

// File: tb/tb_dm_subword_mem.sv
// tb_dm_subword_mem: directed scoreboard bench over three latency variants (RD_LAT 1, 2, 3)
module tb_dm_subword_mem;
  logic clk = 1'b0;
  logic rst, wmem, sign;
  logic [1:0] size;
  logic [31:0] addr, datain;
  logic [2:0] req, ready, rvalid, err;
  logic [31:0] dout [3];
  int total = 0, passed = 0;
  typedef struct packed {logic [31:0] d; logic e;} exp_t;
  exp_t q [$];
  always #5 clk = ~clk;
  dm_subword_mem #(.ADDR_W(32), .DEPTH_WORDS(64), .RD_LAT(1)) u0 (
    .clk(clk), .rst(rst), .req_i(req[0]), .wmem_i(wmem), .size_i(size), .sign_ext_i(sign),
    .addr_i(addr), .datain_i(datain), .ready_o(ready[0]), .rvalid_o(rvalid[0]),
    .dataout_o(dout[0]), .err_o(err[0]));
  dm_subword_mem #(.ADDR_W(32), .DEPTH_WORDS(64), .RD_LAT(2)) u1 (
    .clk(clk), .rst(rst), .req_i(req[1]), .wmem_i(wmem), .size_i(size), .sign_ext_i(sign),
    .addr_i(addr), .datain_i(datain), .ready_o(ready[1]), .rvalid_o(rvalid[1]),
    .dataout_o(dout[1]), .err_o(err[1]));
  dm_subword_mem #(.ADDR_W(32), .DEPTH_WORDS(64), .RD_LAT(3)) u2 (
    .clk(clk), .rst(rst), .req_i(req[2]), .wmem_i(wmem), .size_i(size), .sign_ext_i(sign),
    .addr_i(addr), .datain_i(datain), .ready_o(ready[2]), .rvalid_o(rvalid[2]),
    .dataout_o(dout[2]), .err_o(err[2]));
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask
  task automatic drive(int k, logic w, logic [31:0] a, logic [1:0] sz, logic sg, logic [31:0] d);
    req[k] = 1'b1; wmem = w; addr = a; size = sz; sign = sg; datain = d;
  endtask
  task automatic compare(int k);
    exp_t e;
    chk("sb_depth", q.size(), 1);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("ld_data", dout[k], e.d);
      chk("ld_err", {31'd0, err[k]}, {31'd0, e.e});
    end
  endtask
  task automatic store(int k, logic [31:0] a, logic [1:0] sz, logic [31:0] d, logic e);
    drive(k, 1'b1, a, sz, 1'b0, d);
    @(negedge clk);
    req[k] = 1'b0;
    chk("st_err", {31'd0, err[k]}, {31'd0, e});
  endtask
  task automatic load(int k, logic [31:0] a, logic [1:0] sz, logic sg, logic [31:0] d, logic e, int lat);
    int n;
    q.push_back('{d: d, e: e});
    drive(k, 1'b0, a, sz, sg, 32'd0);
    @(negedge clk);
    req[k] = 1'b0;
    n = 1;
    while (!rvalid[k] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("ld_lat", n, lat);
    compare(k);
    @(negedge clk);
    chk("rv_pulse", {31'd0, rvalid[k]}, 32'd0);
  endtask
  initial begin
    int n;
    rst = 1'b1; req = '0; wmem = 1'b0; size = '0; sign = 1'b0; addr = '0; datain = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", {31'd0, ready[k]}, 32'd1);
      chk("rst_rvalid", {31'd0, rvalid[k]}, 32'd0);
      chk("rst_err", {31'd0, err[k]}, 32'd0);
      chk("rst_dout", dout[k], 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    // T1 word round trip, single-cycle latency
    store(0, 32'h10, 2'b10, 32'h12345678, 1'b0);
    load(0, 32'h10, 2'b10, 1'b0, 32'h12345678, 1'b0, 1);
    // T2 byte lane 3 onto a cleared word
    store(0, 32'h10, 2'b10, 32'h0, 1'b0);
    store(0, 32'h13, 2'b00, 32'hFFFFFFAB, 1'b0);
    load(0, 32'h10, 2'b10, 1'b0, 32'hAB000000, 1'b0, 1);
    load(0, 32'h13, 2'b00, 1'b1, 32'hFFFFFFAB, 1'b0, 1);
    load(0, 32'h13, 2'b00, 1'b0, 32'h000000AB, 1'b0, 1);
    load(0, 32'h12, 2'b00, 1'b1, 32'h00000000, 1'b0, 1);
    // T3 upper half, misaligned half store, then a byte into lane 1
    store(0, 32'h20, 2'b10, 32'h0, 1'b0);
    store(0, 32'h22, 2'b01, 32'h12348001, 1'b0);
    load(0, 32'h22, 2'b01, 1'b1, 32'hFFFF8001, 1'b0, 1);
    load(0, 32'h22, 2'b01, 1'b0, 32'h00008001, 1'b0, 1);
    store(0, 32'h21, 2'b01, 32'h0000FFFF, 1'b1);
    load(0, 32'h20, 2'b10, 1'b0, 32'h80010000, 1'b0, 1);
    store(0, 32'h21, 2'b00, 32'h0000007F, 1'b0);
    load(0, 32'h21, 2'b00, 1'b1, 32'h0000007F, 1'b0, 1);
    load(0, 32'h20, 2'b01, 1'b1, 32'h00007F00, 1'b0, 1);
    // store at edge N, load of the same word accepted at N+1
    store(0, 32'h30, 2'b10, 32'h55AA55AA, 1'b0);
    load(0, 32'h30, 2'b10, 1'b0, 32'h55AA55AA, 1'b0, 1);
    // T5 out-of-range, misaligned and reserved-size faults
    load(0, 32'h100, 2'b10, 1'b0, 32'h0, 1'b1, 1);
    load(0, 32'h32, 2'b10, 1'b0, 32'h0, 1'b1, 1);
    store(0, 32'h0, 2'b10, 32'hCAFEF00D, 1'b0);
    store(0, 32'h0, 2'b11, 32'h11111111, 1'b1);
    load(0, 32'h0, 2'b10, 1'b0, 32'hCAFEF00D, 1'b0, 1);
    load(0, 32'h0, 2'b11, 1'b0, 32'h0, 1'b1, 1);
    store(0, 32'h104, 2'b10, 32'h0, 1'b1);
    // store coinciding with reset is discarded
    store(0, 32'h50, 2'b10, 32'h00000001, 1'b0);
    drive(0, 1'b1, 32'h50, 2'b10, 1'b0, 32'h00000099);
    rst = 1'b1;
    @(negedge clk);
    req[0] = 1'b0; rst = 1'b0;
    load(0, 32'h50, 2'b10, 1'b0, 32'h00000001, 1'b0, 1);
    // T4 RD_LAT=3 with req held through the busy window
    store(2, 32'h40, 2'b10, 32'hDEADBEEF, 1'b0);
    q.push_back('{d: 32'hDEADBEEF, e: 1'b0});
    drive(2, 1'b0, 32'h40, 2'b10, 1'b0, 32'd0);
    @(negedge clk);
    chk("t4_rdy_c1", {31'd0, ready[2]}, 32'd0);
    chk("t4_rv_c1", {31'd0, rvalid[2]}, 32'd0);
    @(negedge clk);
    chk("t4_rdy_c2", {31'd0, ready[2]}, 32'd0);
    chk("t4_rv_c2", {31'd0, rvalid[2]}, 32'd0);
    @(negedge clk);
    chk("t4_rdy_c3", {31'd0, ready[2]}, 32'd0);
    chk("t4_rv_c3", {31'd0, rvalid[2]}, 32'd1);
    compare(2);
    q.push_back('{d: 32'hDEADBEEF, e: 1'b0});
    @(negedge clk);
    chk("t4_rdy_c4", {31'd0, ready[2]}, 32'd1);
    @(negedge clk);
    req[2] = 1'b0;
    n = 1;
    while (!rvalid[2] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("t4_lat2", n, 3);
    compare(2);
    @(negedge clk);
    // T6 reset during RD aborts the load
    store(1, 32'h8, 2'b10, 32'h11112222, 1'b0);
    load(1, 32'h8, 2'b10, 1'b0, 32'h11112222, 1'b0, 2);
    drive(1, 1'b0, 32'h8, 2'b10, 1'b0, 32'd0);
    @(negedge clk);
    req[1] = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_rv", {31'd0, rvalid[1]}, 32'd0);
    chk("t6_rdy", {31'd0, ready[1]}, 32'd1);
    chk("t6_dout", dout[1], 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("t6_norv", {31'd0, rvalid[1]}, 32'd0);
    end
    load(1, 32'h8, 2'b10, 1'b0, 32'h11112222, 1'b0, 2);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
